lsu_icb_tgt_splt: RTL and testbench
===================================

// Module: lsu_icb_tgt_splt
// PURPOSE
//  In-order ICB command splitter directly downstream of the LSU. Decodes each LSU
//  command address against ITCM/DTCM region indicators and forwards it to ITCM, DTCM or BIU.
//  Tracks outstanding commands in a small FIFO so responses return to the LSU in issue order.
//  Zero-cycle command and response pass-through.
// PARAMETERS
//  OUTS_DEPTH  2   max outstanding commands (FIFO entries), >=1
//  ITCM_AW     16  ITCM region size exponent; compare addr[31:ITCM_AW]
//  DTCM_AW     16  DTCM region size exponent; compare addr[31:DTCM_AW]
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   async reset, active-high
//  itcm_region_indic   in   32  ITCM base
//  dtcm_region_indic   in   32  DTCM base
//  i_icb_cmd_valid     in   1   LSU command valid
//  i_icb_cmd_ready     out  1   command accepted
//  i_icb_cmd_addr      in   32  byte address
//  i_icb_cmd_read      in   1   1=read, 0=write
//  i_icb_cmd_wdata     in   32  write data
//  i_icb_cmd_wmask     in   4   byte enables
//  i_icb_cmd_size      in   2   0=B,1=H,2=W
//  i_icb_rsp_valid     out  1   response to LSU valid
//  i_icb_rsp_ready     in   1   LSU accepts response
//  i_icb_rsp_err       out  1   bus error
//  i_icb_rsp_excl_ok   out  1   exclusive success
//  i_icb_rsp_rdata     out  32  read data
//  <t>_icb_cmd_valid/ready/addr/read/wdata/wmask/size  out/in/out...  per-target command, t in {itcm,dtcm,biu}
//  <t>_icb_rsp_valid/ready/err/excl_ok/rdata  in/out/in/in/in  per-target response
//  outs_cnt            out  $clog2(OUTS_DEPTH+1)  outstanding count
//  splt_proto_err      out  1   sticky: target responded with no matching outstanding entry
// BEHAVIOUR
//  Reset: FIFO empty, outs_cnt=0, splt_proto_err=0; all *_valid/*_ready outputs 0 while FIFO empty
//   and no input valid. Reset mid-operation discards in-flight tracking; late responses then set
//   splt_proto_err.
//  Decode: ITCM if addr[31:ITCM_AW]==itcm_region_indic[31:ITCM_AW]; else DTCM if
//   addr[31:DTCM_AW]==dtcm_region_indic[31:DTCM_AW]; else BIU. ITCM wins on overlap.
//  Cmd fields broadcast to all targets; only selected <t>_icb_cmd_valid asserts.
//  blocked = !empty && (sel != last pushed target). Different-target issue waits for FIFO drain.
//  <t>_cmd_valid = i_valid & sel==t & !full & !blocked; i_cmd_ready = sel target ready & !full & !blocked.
//  Push target id on cmd handshake. No push-through-pop bypass: full stalls even on same-cycle pop.
//  Response: head=FIFO head id; i_rsp_* = head target rsp_* gated by !empty;
//   <t>_rsp_ready = i_rsp_ready & !empty & head==t. Pop on i_rsp handshake.
//  Non-head target rsp_valid held off (ready=0). Sets splt_proto_err only when FIFO empty or
//   when rsp_valid from t != head && t != last pushed. Cleared only by rst.
//  Simultaneous push+pop: outs_cnt unchanged, FIFO pointers both advance.
//  Pointers wrap modulo OUTS_DEPTH. outs_cnt saturates at OUTS_DEPTH by construction.
// STRUCTURE
//  Package lsu_splt_pkg: typedef enum logic[1:0] {TGT_ITCM, TGT_DTCM, TGT_BIU} tgt_e; size constants.
//  Sub-module lsu_splt_fifo: sync FIFO of tgt_e, DEPTH param, full/empty/count, async active-high rst.
//  Top: decode, issue/block logic, response mux, sticky error flop.
// TESTING (itcm_region_indic=0x8000_0000, dtcm_region_indic=0x9000_0000, OUTS_DEPTH=2)
//  1 Read addr 0x8000_0010, itcm ready -> itcm_cmd_valid=1 only, outs_cnt=1.
//    itcm rsp rdata 0x1234_5678 -> i_rsp_rdata=0x1234_5678, outs_cnt=0.
//  2 Read 0x9000_0004 then 0x9000_0008 back-to-back, no rsp -> both accepted, outs_cnt=2;
//    third 0x9000_000C -> i_cmd_ready=0 until one rsp pops.
//  3 DTCM read outstanding, then cmd to 0x2000_0000 -> i_cmd_ready=0, biu_cmd_valid=0 until
//    dtcm rsp handshakes; then BIU accepted.
//  4 Write 0x2000_0000 wmask=4'b0011; biu rsp err=1 -> i_rsp_err=1; with i_rsp_ready=0,
//    rsp held and outs_cnt stays 1.
//  5 FIFO empty, dtcm_rsp_valid=1 -> dtcm_rsp_ready=0, splt_proto_err=1 next cycle, sticky.
//  6 Assert rst with outs_cnt=2 -> outs_cnt=0, all valids 0 asynchronously; err cleared.

Source files
------------

// File: rtl/lsu_splt_pkg.sv
// Shared types for the LSU ICB target splitter: target ids and ICB transfer-size codes.
package lsu_splt_pkg;

  typedef enum logic [1:0] {
    TGT_ITCM = 2'd0,
    TGT_DTCM = 2'd1,
    TGT_BIU  = 2'd2
  } tgt_e;

  localparam int TGT_W = 2;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/lsu_splt_fifo.sv
// In-order tracker of target ids for outstanding commands; push/pop take effect at the clock edge.
// No write-through: a full FIFO refuses push even if a pop happens in the same cycle.
module lsu_splt_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DW-1:0]                push_dat,
  input  logic                         pop,
  output logic [DW-1:0]                pop_dat,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == CNT_FULL);
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem_q[rptr_q];
  assign count   = cnt_q;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) begin
      mem_d[wptr_q] = push_dat;
      wptr_d        = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    end
    if (pop_ok) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/lsu_icb_tgt_splt.sv
// Routes LSU ICB commands to ITCM/DTCM/BIU with zero-cycle pass-through and returns responses in issue order.
// Stalls commands when the tracker is full or the target differs from the in-flight one; holds off non-head responses.
module lsu_icb_tgt_splt
  import lsu_splt_pkg::*;
#(
  parameter int OUTS_DEPTH = 2,
  parameter int ITCM_AW    = 16,
  parameter int DTCM_AW    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [31:0]                       itcm_region_indic,
  input  logic [31:0]                       dtcm_region_indic,

  input  logic                              i_icb_cmd_valid,
  output logic                              i_icb_cmd_ready,
  input  logic [31:0]                       i_icb_cmd_addr,
  input  logic                              i_icb_cmd_read,
  input  logic [31:0]                       i_icb_cmd_wdata,
  input  logic [3:0]                        i_icb_cmd_wmask,
  input  logic [1:0]                        i_icb_cmd_size,
  output logic                              i_icb_rsp_valid,
  input  logic                              i_icb_rsp_ready,
  output logic                              i_icb_rsp_err,
  output logic                              i_icb_rsp_excl_ok,
  output logic [31:0]                       i_icb_rsp_rdata,

  output logic                              itcm_icb_cmd_valid,
  input  logic                              itcm_icb_cmd_ready,
  output logic [31:0]                       itcm_icb_cmd_addr,
  output logic                              itcm_icb_cmd_read,
  output logic [31:0]                       itcm_icb_cmd_wdata,
  output logic [3:0]                        itcm_icb_cmd_wmask,
  output logic [1:0]                        itcm_icb_cmd_size,
  input  logic                              itcm_icb_rsp_valid,
  output logic                              itcm_icb_rsp_ready,
  input  logic                              itcm_icb_rsp_err,
  input  logic                              itcm_icb_rsp_excl_ok,
  input  logic [31:0]                       itcm_icb_rsp_rdata,

  output logic                              dtcm_icb_cmd_valid,
  input  logic                              dtcm_icb_cmd_ready,
  output logic [31:0]                       dtcm_icb_cmd_addr,
  output logic                              dtcm_icb_cmd_read,
  output logic [31:0]                       dtcm_icb_cmd_wdata,
  output logic [3:0]                        dtcm_icb_cmd_wmask,
  output logic [1:0]                        dtcm_icb_cmd_size,
  input  logic                              dtcm_icb_rsp_valid,
  output logic                              dtcm_icb_rsp_ready,
  input  logic                              dtcm_icb_rsp_err,
  input  logic                              dtcm_icb_rsp_excl_ok,
  input  logic [31:0]                       dtcm_icb_rsp_rdata,

  output logic                              biu_icb_cmd_valid,
  input  logic                              biu_icb_cmd_ready,
  output logic [31:0]                       biu_icb_cmd_addr,
  output logic                              biu_icb_cmd_read,
  output logic [31:0]                       biu_icb_cmd_wdata,
  output logic [3:0]                        biu_icb_cmd_wmask,
  output logic [1:0]                        biu_icb_cmd_size,
  input  logic                              biu_icb_rsp_valid,
  output logic                              biu_icb_rsp_ready,
  input  logic                              biu_icb_rsp_err,
  input  logic                              biu_icb_rsp_excl_ok,
  input  logic [31:0]                       biu_icb_rsp_rdata,

  output logic [$clog2(OUTS_DEPTH+1)-1:0]   outs_cnt,
  output logic                              splt_proto_err
);

  tgt_e             sel;
  tgt_e             head;
  tgt_e             last_tgt_q, last_tgt_d;
  logic [TGT_W-1:0] head_raw;
  logic             itcm_hit, dtcm_hit;
  logic             fifo_full, fifo_empty;
  logic             blocked, issue_ok, sel_rdy;
  logic             push, pop;
  logic             head_rsp_vld;
  logic             stray_rsp;
  logic             proto_err_q, proto_err_d;

  // XOR-then-shift compares only the bits above the region size.
  assign itcm_hit = ((i_icb_cmd_addr ^ itcm_region_indic) >> ITCM_AW) == 32'd0;
  assign dtcm_hit = ((i_icb_cmd_addr ^ dtcm_region_indic) >> DTCM_AW) == 32'd0;

  always_comb begin
    sel     = TGT_BIU;
    sel_rdy = biu_icb_cmd_ready;
    if (itcm_hit) begin
      sel     = TGT_ITCM;
      sel_rdy = itcm_icb_cmd_ready;
    end else if (dtcm_hit) begin
      sel     = TGT_DTCM;
      sel_rdy = dtcm_icb_cmd_ready;
    end
  end

  assign blocked  = !fifo_empty && (sel != last_tgt_q);
  assign issue_ok = i_icb_cmd_valid && !fifo_full && !blocked;

  assign itcm_icb_cmd_valid = issue_ok && (sel == TGT_ITCM);
  assign dtcm_icb_cmd_valid = issue_ok && (sel == TGT_DTCM);
  assign biu_icb_cmd_valid  = issue_ok && (sel == TGT_BIU);
  assign i_icb_cmd_ready    = issue_ok && sel_rdy;
  assign push               = i_icb_cmd_valid && i_icb_cmd_ready;

  assign itcm_icb_cmd_addr  = i_icb_cmd_addr;
  assign itcm_icb_cmd_read  = i_icb_cmd_read;
  assign itcm_icb_cmd_wdata = i_icb_cmd_wdata;
  assign itcm_icb_cmd_wmask = i_icb_cmd_wmask;
  assign itcm_icb_cmd_size  = i_icb_cmd_size;
  assign dtcm_icb_cmd_addr  = i_icb_cmd_addr;
  assign dtcm_icb_cmd_read  = i_icb_cmd_read;
  assign dtcm_icb_cmd_wdata = i_icb_cmd_wdata;
  assign dtcm_icb_cmd_wmask = i_icb_cmd_wmask;
  assign dtcm_icb_cmd_size  = i_icb_cmd_size;
  assign biu_icb_cmd_addr   = i_icb_cmd_addr;
  assign biu_icb_cmd_read   = i_icb_cmd_read;
  assign biu_icb_cmd_wdata  = i_icb_cmd_wdata;
  assign biu_icb_cmd_wmask  = i_icb_cmd_wmask;
  assign biu_icb_cmd_size   = i_icb_cmd_size;

  lsu_splt_fifo #(
    .DEPTH (OUTS_DEPTH),
    .DW    (TGT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (sel),
    .pop      (pop),
    .pop_dat  (head_raw),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outs_cnt)
  );

  assign head = tgt_e'(head_raw);

  always_comb begin
    head_rsp_vld       = 1'b0;
    i_icb_rsp_err      = 1'b0;
    i_icb_rsp_excl_ok  = 1'b0;
    i_icb_rsp_rdata    = '0;
    itcm_icb_rsp_ready = 1'b0;
    dtcm_icb_rsp_ready = 1'b0;
    biu_icb_rsp_ready  = 1'b0;
    if (!fifo_empty) begin
      case (head)
        TGT_ITCM: begin
          head_rsp_vld       = itcm_icb_rsp_valid;
          i_icb_rsp_err      = itcm_icb_rsp_err;
          i_icb_rsp_excl_ok  = itcm_icb_rsp_excl_ok;
          i_icb_rsp_rdata    = itcm_icb_rsp_rdata;
          itcm_icb_rsp_ready = i_icb_rsp_ready;
        end
        TGT_DTCM: begin
          head_rsp_vld       = dtcm_icb_rsp_valid;
          i_icb_rsp_err      = dtcm_icb_rsp_err;
          i_icb_rsp_excl_ok  = dtcm_icb_rsp_excl_ok;
          i_icb_rsp_rdata    = dtcm_icb_rsp_rdata;
          dtcm_icb_rsp_ready = i_icb_rsp_ready;
        end
        TGT_BIU: begin
          head_rsp_vld       = biu_icb_rsp_valid;
          i_icb_rsp_err      = biu_icb_rsp_err;
          i_icb_rsp_excl_ok  = biu_icb_rsp_excl_ok;
          i_icb_rsp_rdata    = biu_icb_rsp_rdata;
          biu_icb_rsp_ready  = i_icb_rsp_ready;
        end
        default: ;
      endcase
    end
  end

  assign i_icb_rsp_valid = head_rsp_vld;
  assign pop             = i_icb_rsp_valid && i_icb_rsp_ready;

  // A response is stray if nothing is tracked, or it comes from neither the head nor the latest target.
  always_comb begin
    stray_rsp = 1'b0;
    if (itcm_icb_rsp_valid && (fifo_empty || (head != TGT_ITCM && last_tgt_q != TGT_ITCM)))
      stray_rsp = 1'b1;
    if (dtcm_icb_rsp_valid && (fifo_empty || (head != TGT_DTCM && last_tgt_q != TGT_DTCM)))
      stray_rsp = 1'b1;
    if (biu_icb_rsp_valid && (fifo_empty || (head != TGT_BIU && last_tgt_q != TGT_BIU)))
      stray_rsp = 1'b1;
  end

  assign proto_err_d    = proto_err_q | stray_rsp;
  assign last_tgt_d     = push ? sel : last_tgt_q;
  assign splt_proto_err = proto_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_tgt_q  <= TGT_ITCM;
      proto_err_q <= 1'b0;
    end else begin
      last_tgt_q  <= last_tgt_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_lsu_icb_tgt_splt.sv
// Directed bench for lsu_icb_tgt_splt: queue-based reference model checked every cycle plus literal spot checks.
module tb_lsu_icb_tgt_splt;

  localparam logic [31:0] ITCM_BASE = 32'h8000_0000;
  localparam logic [31:0] DTCM_BASE = 32'h9000_0000;
  localparam int          DEPTH     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] itcm_indic, dtcm_indic;
  logic        i_valid, i_read, i_rsp_ready;
  logic [31:0] i_addr, i_wdata;
  logic [3:0]  i_wmask;
  logic [1:0]  i_size;
  logic [2:0]  t_crdy, t_rv, t_err, t_exc;
  logic [31:0] t_rdata [3];

  logic        o_crdy, o_rv, o_rerr, o_rexc, o_perr;
  logic [31:0] o_rdata;
  logic [2:0]  o_cv, o_rr, o_read;
  logic [31:0] o_addr [3];
  logic [31:0] o_wdata [3];
  logic [3:0]  o_wmask [3];
  logic [1:0]  o_size [3];
  logic [1:0]  o_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_icb_tgt_splt #(.OUTS_DEPTH(DEPTH), .ITCM_AW(16), .DTCM_AW(16)) dut (
    .clk(clk), .rst(rst),
    .itcm_region_indic(itcm_indic), .dtcm_region_indic(dtcm_indic),
    .i_icb_cmd_valid(i_valid), .i_icb_cmd_ready(o_crdy), .i_icb_cmd_addr(i_addr),
    .i_icb_cmd_read(i_read), .i_icb_cmd_wdata(i_wdata), .i_icb_cmd_wmask(i_wmask),
    .i_icb_cmd_size(i_size),
    .i_icb_rsp_valid(o_rv), .i_icb_rsp_ready(i_rsp_ready), .i_icb_rsp_err(o_rerr),
    .i_icb_rsp_excl_ok(o_rexc), .i_icb_rsp_rdata(o_rdata),
    .itcm_icb_cmd_valid(o_cv[0]), .itcm_icb_cmd_ready(t_crdy[0]), .itcm_icb_cmd_addr(o_addr[0]),
    .itcm_icb_cmd_read(o_read[0]), .itcm_icb_cmd_wdata(o_wdata[0]), .itcm_icb_cmd_wmask(o_wmask[0]),
    .itcm_icb_cmd_size(o_size[0]),
    .itcm_icb_rsp_valid(t_rv[0]), .itcm_icb_rsp_ready(o_rr[0]), .itcm_icb_rsp_err(t_err[0]),
    .itcm_icb_rsp_excl_ok(t_exc[0]), .itcm_icb_rsp_rdata(t_rdata[0]),
    .dtcm_icb_cmd_valid(o_cv[1]), .dtcm_icb_cmd_ready(t_crdy[1]), .dtcm_icb_cmd_addr(o_addr[1]),
    .dtcm_icb_cmd_read(o_read[1]), .dtcm_icb_cmd_wdata(o_wdata[1]), .dtcm_icb_cmd_wmask(o_wmask[1]),
    .dtcm_icb_cmd_size(o_size[1]),
    .dtcm_icb_rsp_valid(t_rv[1]), .dtcm_icb_rsp_ready(o_rr[1]), .dtcm_icb_rsp_err(t_err[1]),
    .dtcm_icb_rsp_excl_ok(t_exc[1]), .dtcm_icb_rsp_rdata(t_rdata[1]),
    .biu_icb_cmd_valid(o_cv[2]), .biu_icb_cmd_ready(t_crdy[2]), .biu_icb_cmd_addr(o_addr[2]),
    .biu_icb_cmd_read(o_read[2]), .biu_icb_cmd_wdata(o_wdata[2]), .biu_icb_cmd_wmask(o_wmask[2]),
    .biu_icb_cmd_size(o_size[2]),
    .biu_icb_rsp_valid(t_rv[2]), .biu_icb_rsp_ready(o_rr[2]), .biu_icb_rsp_err(t_err[2]),
    .biu_icb_rsp_excl_ok(t_exc[2]), .biu_icb_rsp_rdata(t_rdata[2]),
    .outs_cnt(o_cnt), .splt_proto_err(o_perr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of target ids (0=ITCM, 1=DTCM, 2=BIU) still awaiting a response.
  int         q[$];
  bit         m_err;
  int         e_sel;
  bit         e_iss, e_crdy, e_rv, e_rerr, e_rexc;
  bit  [2:0]  e_cv, e_rr;
  logic [31:0] e_rdata;

  function automatic int region(input logic [31:0] a);
    if ((a >> 16) == (itcm_indic >> 16)) return 0;
    if ((a >> 16) == (dtcm_indic >> 16)) return 1;
    return 2;
  endfunction

  function automatic void model_eval();
    int h;
    e_sel   = region(i_addr);
    e_iss   = i_valid && (q.size() < DEPTH) && !(q.size() > 0 && q[$] != e_sel);
    e_cv    = '0;
    if (e_iss) e_cv[e_sel] = 1'b1;
    e_crdy  = e_iss && t_crdy[e_sel];
    e_rr    = '0;
    e_rv    = 1'b0;
    e_rerr  = 1'b0;
    e_rexc  = 1'b0;
    e_rdata = '0;
    if (q.size() > 0) begin
      h       = q[0];
      e_rv    = t_rv[h];
      e_rerr  = t_err[h];
      e_rexc  = t_exc[h];
      e_rdata = t_rdata[h];
      e_rr[h] = i_rsp_ready;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      model_eval();
      for (int t = 0; t < 3; t++)
        if (t_rv[t] && (q.size() == 0 || (t != q[0] && t != q[$]))) m_err = 1'b1;
      if (e_rv && i_rsp_ready) void'(q.pop_front());
      if (i_valid && e_crdy) q.push_back(e_sel);
    end
  end

  always @(negedge clk) begin
    model_eval();
    chk("m_cmd_valid", {29'd0, o_cv}, {29'd0, e_cv});
    chk("m_cmd_ready", {31'd0, o_crdy}, {31'd0, e_crdy});
    chk("m_rsp_ready", {29'd0, o_rr}, {29'd0, e_rr});
    chk("m_rsp_valid", {31'd0, o_rv}, {31'd0, e_rv});
    chk("m_rsp_err", {31'd0, o_rerr}, {31'd0, e_rerr});
    chk("m_rsp_excl", {31'd0, o_rexc}, {31'd0, e_rexc});
    chk("m_rsp_rdata", o_rdata, e_rdata);
    chk("m_outs_cnt", {30'd0, o_cnt}, q.size());
    chk("m_proto_err", {31'd0, o_perr}, {31'd0, m_err});
    for (int k = 0; k < 3; k++) begin
      chk("m_bc_addr", o_addr[k], i_addr);
      chk("m_bc_ctl", {o_read[k], o_wmask[k], o_size[k]}, {i_read, i_wmask, i_size});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bnd_addr [6];
  logic [2:0]  bnd_cv   [6];

  initial begin
    rst = 1'b1;
    itcm_indic = ITCM_BASE; dtcm_indic = DTCM_BASE;
    i_valid = 0; i_addr = 0; i_read = 1; i_wdata = 0; i_wmask = 4'hF; i_size = 2'd2;
    i_rsp_ready = 0; t_crdy = 3'b111; t_rv = 0; t_err = 0; t_exc = 0;
    t_rdata[0] = 32'h1111_0000; t_rdata[1] = 32'h2222_0000; t_rdata[2] = 32'h3333_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs_cnt", {30'd0, o_cnt}, 0);
    chk("rst_proto_err", {31'd0, o_perr}, 0);
    chk("rst_cmd_ready", {31'd0, o_crdy}, 0);
    tick(); rst = 1'b0;

    // Decode boundaries with all targets stalled so nothing is issued.
    t_crdy = 3'b000;
    bnd_addr = '{32'h8000_0000, 32'h8000_FFFF, 32'h8001_0000, 32'h7FFF_FFFC, 32'h9000_FFFC, 32'h9001_0000};
    bnd_cv   = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b010, 3'b100};
    i_valid = 1;
    for (int n = 0; n < 6; n++) begin
      i_addr = bnd_addr[n];
      @(negedge clk);
      chk("decode", {29'd0, o_cv}, {29'd0, bnd_cv[n]});
      tick();
    end
    dtcm_indic = ITCM_BASE; i_addr = 32'h8000_0010;
    @(negedge clk);
    chk("overlap_itcm", {29'd0, o_cv}, 32'd1);
    tick();
    dtcm_indic = DTCM_BASE; i_valid = 0; t_crdy = 3'b111;

    // 1: ITCM read and response.
    i_valid = 1; i_addr = 32'h8000_0010; i_read = 1;
    @(negedge clk);
    chk("t1_cv", {29'd0, o_cv}, 32'd1);
    chk("t1_rdy", {31'd0, o_crdy}, 1);
    tick(); i_valid = 0;
    @(negedge clk);
    chk("t1_cnt1", {30'd0, o_cnt}, 1);
    tick(); t_rv[0] = 1; t_rdata[0] = 32'h1234_5678; i_rsp_ready = 1;
    @(negedge clk);
    chk("t1_rdata", o_rdata, 32'h1234_5678);
    chk("t1_rv", {31'd0, o_rv}, 1);
    tick(); t_rv = 0;
    @(negedge clk);
    chk("t1_cnt0", {30'd0, o_cnt}, 0);

    // 2: two DTCM reads fill the tracker; third waits for a pop, no same-cycle bypass.
    tick(); i_valid = 1; i_addr = 32'h9000_0004;
    tick(); i_addr = 32'h9000_0008;
    tick(); i_addr = 32'h9000_000C;
    @(negedge clk);
    chk("t2_cnt2", {30'd0, o_cnt}, 2);
    chk("t2_full_rdy", {31'd0, o_crdy}, 0);
    tick(); t_rv[1] = 1;
    @(negedge clk);
    chk("t2_nobypass", {31'd0, o_crdy}, 0);
    tick(); t_rv[1] = 0;
    @(negedge clk);
    chk("t2_rdy_after_pop", {31'd0, o_crdy}, 1);
    chk("t2_cnt1", {30'd0, o_cnt}, 1);
    tick(); i_valid = 0; t_rv[1] = 1;
    @(negedge clk);
    chk("t2_cnt2b", {30'd0, o_cnt}, 2);
    tick(); tick(); t_rv = 0;
    @(negedge clk);
    chk("t2_drained", {30'd0, o_cnt}, 0);

    // 3: BIU command blocked behind an outstanding DTCM read.
    tick(); i_valid = 1; i_addr = 32'h9000_0004;
    tick(); i_addr = 32'h2000_0000;
    @(negedge clk);
    chk("t3_blk_rdy", {31'd0, o_crdy}, 0);
    chk("t3_blk_cv", {29'd0, o_cv}, 0);
    tick(); t_rv[1] = 1;
    @(negedge clk);
    chk("t3_blk_biu", {31'd0, o_cv[2]}, 0);
    tick(); t_rv = 0;
    @(negedge clk);
    chk("t3_biu_cv", {29'd0, o_cv}, 32'd4);
    chk("t3_biu_rdy", {31'd0, o_crdy}, 1);
    tick(); i_valid = 0; t_rv[2] = 1;
    tick(); t_rv = 0;

    // 4: BIU write with error response held by LSU backpressure.
    i_valid = 1; i_read = 0; i_wmask = 4'b0011; i_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("t4_wmask", {28'd0, o_wmask[2]}, 32'd3);
    tick(); i_valid = 0; i_rsp_ready = 0; t_rv[2] = 1; t_err[2] = 1;
    @(negedge clk);
    chk("t4_err", {31'd0, o_rerr}, 1);
    tick();
    @(negedge clk);
    chk("t4_held", {31'd0, o_rv}, 1);
    chk("t4_cnt", {30'd0, o_cnt}, 1);
    tick(); i_rsp_ready = 1;
    tick(); t_rv = 0; t_err = 0; i_read = 1; i_wmask = 4'hF;

    // 5: response with nothing outstanding.
    t_rv[1] = 1;
    @(negedge clk);
    chk("t5_rr", {29'd0, o_rr}, 0);
    chk("t5_err_pre", {31'd0, o_perr}, 0);
    tick(); t_rv = 0;
    @(negedge clk);
    chk("t5_err_set", {31'd0, o_perr}, 1);
    tick();
    @(negedge clk);
    chk("t5_sticky", {31'd0, o_perr}, 1);

    // 6: asynchronous reset with two outstanding, then a late response.
    tick(); i_valid = 1; i_addr = 32'h9000_0010;
    tick(); tick(); i_valid = 0;
    @(negedge clk);
    chk("t6_cnt2", {30'd0, o_cnt}, 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_cnt", {30'd0, o_cnt}, 0);
    chk("t6_async_err", {31'd0, o_perr}, 0);
    chk("t6_async_cv", {29'd0, o_cv}, 0);
    tick(); rst = 1'b0; t_rv[1] = 1;
    tick(); t_rv = 0;
    @(negedge clk);
    chk("t6_late_err", {31'd0, o_perr}, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
